// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: keeps one memory request in flight and holds the fetched word for IF/ID.
// A redirect during an outstanding request waits in DRAIN for the stale response before refetching.
module if_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hazDetect_IF_ID,
   input  logic        branchTaken,
   input  logic [31:0] branchTarget,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemValid,
   input  logic [31:0] imemRdata,
   output logic [31:0] pc_o,
   output logic [31:0] pcPlusFour_o,
   output logic [31:0] inst_o,
   output logic        instValid_o,
   output logic        IF_Flush
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] fetch_pc;
   logic [31:0] pending_pc;
   logic [31:0] pc_plus_four;

   assign pc_plus_four = fetch_pc + 32'd4;
   assign imemAddr     = fetch_pc;
   assign IF_Flush     = branchTaken;

   // While holding, the next request goes out only when the held word is being handed over
   always_comb begin
      imemReq = 1'b1;
      if (state == HOLD)
         imemReq = hazDetect_IF_ID && !branchTaken;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= FETCH;
         fetch_pc     <= RESET_VECTOR;
         pending_pc   <= 32'd0;
         instValid_o  <= 1'b0;
         inst_o       <= NOP_INST;
         pc_o         <= 32'd0;
         pcPlusFour_o <= 32'd0;
      end else if (branchTaken) begin
         instValid_o  <= 1'b0;
         inst_o       <= NOP_INST;
         pc_o         <= 32'd0;
         pcPlusFour_o <= 32'd0;
         // No request is in flight in HOLD, so the target can be fetched right away
         if (state == HOLD || imemValid) begin
            fetch_pc <= branchTarget;
            state    <= FETCH;
         end else begin
            pending_pc <= branchTarget;
            state      <= DRAIN;
         end
      end else begin
         case (state)
            FETCH: begin
               if (imemValid) begin
                  inst_o       <= imemRdata;
                  pc_o         <= fetch_pc;
                  pcPlusFour_o <= pc_plus_four;
                  fetch_pc     <= pc_plus_four;
                  instValid_o  <= 1'b1;
                  state        <= HOLD;
               end
            end
            HOLD: begin
               if (hazDetect_IF_ID) begin
                  if (imemValid) begin
                     inst_o       <= imemRdata;
                     pc_o         <= fetch_pc;
                     pcPlusFour_o <= pc_plus_four;
                     fetch_pc     <= pc_plus_four;
                     instValid_o  <= 1'b1;
                  end else begin
                     instValid_o  <= 1'b0;
                     inst_o       <= NOP_INST;
                     pc_o         <= 32'd0;
                     pcPlusFour_o <= 32'd0;
                     state        <= FETCH;
                  end
               end
            end
            DRAIN: begin
               if (imemValid) begin
                  fetch_pc <= pending_pc;
                  state    <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule
